multiword_comparator: RTL

MULTIWORD_COMPARATOR -- requirements
Module: multiword_comparator

---
 rtl/multiword_comparator_pkg.sv | 22 ++
 rtl/multiword_comparator_word_cmp.sv | 23 ++
 rtl/multiword_comparator.sv | 117 +++++++++++
 3 files changed

// File: rtl/multiword_comparator_pkg.sv
// Shared types for the multi-word comparator: FSM states, result encoding
// and the word-counter width helper.
package multiword_comparator_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COMPARE = 2'b01,
    DONE    = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    EQ = 2'b00,
    GT = 2'b01,
    LT = 2'b10
  } result_t;

  // A single-word operand still needs a 1-bit counter.
  function automatic int cnt_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/multiword_comparator_word_cmp.sv
// Combinational single-word magnitude compare, two's-complement when
// is_signed is high.
module word_cmp #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  always_comb begin
    eq = (a == b);
    if (is_signed)
      gt = ($signed(a) > $signed(b));
    else
      gt = (a > b);
    lt = !gt && !eq;
  end

endmodule

// File: rtl/multiword_comparator.sv
// Serial comparator: operands arrive one word per handshake, MSB word first;
// the first differing word decides the result.
module multiword_comparator
  import multiword_comparator_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int WORDS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             A_grt_B,
  output logic             A_less_B,
  output logic             A_eq_B
);

  localparam int CNT_W = cnt_width(WORDS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             signed_lat;
  logic             decided;
  result_t          decision;

  logic    w_gt, w_lt, w_eq;
  result_t final_res;

  // Only the MSB word carries the sign; lower words are plain magnitudes.
  word_cmp #(.WIDTH(WIDTH)) u_word_cmp (
    .a         (A),
    .b         (B),
    .is_signed (signed_lat && (cnt == '0)),
    .gt        (w_gt),
    .lt        (w_lt),
    .eq        (w_eq)
  );

  always_comb begin
    final_res = EQ;
    if (decided)
      final_res = decision;
    else if (w_gt)
      final_res = GT;
    else if (w_lt)
      final_res = LT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      signed_lat <= 1'b0;
      decided    <= 1'b0;
      decision   <= EQ;
      busy       <= 1'b0;
      in_ready   <= 1'b0;
      done       <= 1'b0;
      A_grt_B    <= 1'b0;
      A_less_B   <= 1'b0;
      A_eq_B     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state      <= COMPARE;
            signed_lat <= signed_mode;
            cnt        <= '0;
            decided    <= 1'b0;
            decision   <= EQ;
            busy       <= 1'b1;
            in_ready   <= 1'b1;
          end
        end
        COMPARE: begin
          if (in_valid) begin
            if (!decided && !w_eq) begin
              decided  <= 1'b1;
              decision <= w_gt ? GT : LT;
            end
            // The flags are loaded from final_res so the last word can still decide.
            if (cnt == LAST) begin
              cnt      <= '0;
              state    <= DONE;
              busy     <= 1'b0;
              in_ready <= 1'b0;
              done     <= 1'b1;
              A_grt_B  <= (final_res == GT);
              A_less_B <= (final_res == LT);
              A_eq_B   <= (final_res == EQ);
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          in_ready <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule
